// File: rtl/poly_eval_seq.sv
// Sequential complex polynomial evaluator: w = prod_k (z - zero[k]) for
// k = 0..n_active-1, one complex factor per clock, fixed-point Q(WIDTH-FRAC).FRAC
// with saturation and a sticky per-result overflow flag.
module poly_eval_seq #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int N_ZEROS = 4,
  parameter int AW      = (N_ZEROS > 1) ? $clog2(N_ZEROS) : 1,
  parameter int CW      = $clog2(N_ZEROS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero_we,
  input  logic [AW-1:0]    zero_addr,
  input  logic [WIDTH-1:0] zero_re,
  input  logic [WIDTH-1:0] zero_im,
  input  logic             cnt_we,
  input  logic [CW-1:0]    cnt_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] z_re,
  input  logic [WIDTH-1:0] z_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w_re,
  output logic [WIDTH-1:0] w_im,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE   = WIDTH'(1 << FRAC);
  localparam logic [CW-1:0]           NZ    = CW'(N_ZEROS);

  state_t state, next_state;

  logic signed [WIDTH-1:0] tbl_re [N_ZEROS];
  logic signed [WIDTH-1:0] tbl_im [N_ZEROS];
  logic [CW-1:0]           n_active;

  logic signed [WIDTH-1:0] z_re_q, z_im_q;
  logic signed [WIDTH-1:0] acc_re, acc_im;
  logic [CW-1:0]           k_cnt;
  logic                    ovf_acc;

  logic [CW-1:0]           cnt_clamped;
  logic [CW-1:0]           eff_cnt;
  logic                    addr_ok;
  logic                    last_factor;

  logic signed [WIDTH-1:0] zk_re, zk_im;
  logic [WIDTH:0]          diff_re, diff_im;
  logic                    sub_ovf_re, sub_ovf_im;
  logic signed [WIDTH-1:0] d_re, d_im;

  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*WIDTH:0]   sum_re, sum_im;
  logic signed [2*WIDTH:0]   sh_re, sh_im;
  logic [WIDTH+1:0]          top_re, top_im;
  logic                      mul_ovf_re, mul_ovf_im;
  logic signed [WIDTH-1:0]   m_re, m_im;

  // Control decode: clamped count, the count an acceptance will use (a
  // same-cycle cnt_we wins), table address range, and last-factor detection.
  always_comb begin
    cnt_clamped = (cnt_in > NZ) ? NZ : cnt_in;
    eff_cnt     = cnt_we ? cnt_clamped : n_active;
    addr_ok     = (CW'(zero_addr) < NZ);
    last_factor = (k_cnt == (n_active - CW'(1)));
  end

  // Factor datapath: saturating d = z - zero[k], then full-precision complex
  // multiply acc*d, arithmetic shift by FRAC and saturation back to WIDTH.
  always_comb begin
    zk_re = tbl_re[k_cnt[AW-1:0]];
    zk_im = tbl_im[k_cnt[AW-1:0]];

    diff_re    = {z_re_q[WIDTH-1], z_re_q} - {zk_re[WIDTH-1], zk_re};
    diff_im    = {z_im_q[WIDTH-1], z_im_q} - {zk_im[WIDTH-1], zk_im};
    sub_ovf_re = diff_re[WIDTH] ^ diff_re[WIDTH-1];
    sub_ovf_im = diff_im[WIDTH] ^ diff_im[WIDTH-1];
    d_re       = sub_ovf_re ? (diff_re[WIDTH] ? W_MIN : W_MAX) : diff_re[WIDTH-1:0];
    d_im       = sub_ovf_im ? (diff_im[WIDTH] ? W_MIN : W_MAX) : diff_im[WIDTH-1:0];

    p_rr = acc_re * d_re;
    p_ii = acc_im * d_im;
    p_ri = acc_re * d_im;
    p_ir = acc_im * d_re;

    sum_re = {p_rr[2*WIDTH-1], p_rr} - {p_ii[2*WIDTH-1], p_ii};
    sum_im = {p_ri[2*WIDTH-1], p_ri} + {p_ir[2*WIDTH-1], p_ir};
    sh_re  = sum_re >>> FRAC;
    sh_im  = sum_im >>> FRAC;

    top_re     = sh_re[2*WIDTH:WIDTH-1];
    top_im     = sh_im[2*WIDTH:WIDTH-1];
    mul_ovf_re = !((&top_re) || !(|top_re));
    mul_ovf_im = !((&top_im) || !(|top_im));
    m_re       = mul_ovf_re ? (sh_re[2*WIDTH] ? W_MIN : W_MAX) : sh_re[WIDTH-1:0];
    m_im       = mul_ovf_im ? (sh_im[2*WIDTH] ? W_MIN : W_MAX) : sh_im[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = (eff_cnt == '0) ? DONE : MULT;
      end
      MULT: begin
        if (last_factor) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Table and count writes are only honoured in IDLE so a running evaluation
  // always sees one consistent table; acceptance primes the accumulator and
  // each MULT cycle folds in one factor.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ZEROS; i++) begin
        tbl_re[i] <= '0;
        tbl_im[i] <= '0;
      end
      n_active <= '0;
      z_re_q   <= '0;
      z_im_q   <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      k_cnt    <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (zero_we && addr_ok) begin
            tbl_re[zero_addr] <= zero_re;
            tbl_im[zero_addr] <= zero_im;
          end
          if (cnt_we) n_active <= cnt_clamped;
          if (in_valid) begin
            z_re_q  <= z_re;
            z_im_q  <= z_im;
            acc_re  <= ONE;
            acc_im  <= '0;
            k_cnt   <= '0;
            ovf_acc <= 1'b0;
          end
        end
        MULT: begin
          acc_re  <= m_re;
          acc_im  <= m_im;
          k_cnt   <= k_cnt + CW'(1);
          ovf_acc <= ovf_acc | sub_ovf_re | sub_ovf_im | mul_ovf_re | mul_ovf_im;
        end
        default: begin
        end
      endcase
    end
  end

  assign w_re = acc_re;
  assign w_im = acc_im;
  assign ovf  = ovf_acc;

endmodule
